// File: rtl/tcb_cnn_pkg.sv
// rtl/tcb_cnn_pkg.sv - shared types and arithmetic helpers for the TCB CNN datapath
// Contents:
//   fc_state_t  IDLE/RUN/DONE state encoding of the serial FC layer
//   clog2       ceiling log2 (clog2(1) = 0)
//   acc_width   accumulator width that cannot overflow for n products plus a bias
//   saturate    clamp a signed value to a signed range of the given width
package tcb_cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fc_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // n products plus one bias term, each bounded by a full product.
    function automatic int acc_width(input int data_w, input int weight_w, input int n);
        return data_w + weight_w + clog2(n + 1);
    endfunction

    // Width-generic through a 64-bit carrier; callers cast the result down.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v)
            return max_v;
        else if (value < min_v)
            return min_v;
        else
            return value;
    endfunction

endpackage

// File: rtl/fc_serial_if.sv
// rtl/fc_serial_if.sv - vector handshake and weight memory bus of the serial FC layer
// Signals:
//   layer_in  packed signed input nodes, node j at [j*DATA_WIDTH +: DATA_WIDTH]
//   valid     single-cycle start pulse
//   w_addr    weight memory read address
//   w_en      weight memory read enable
//   w_data    weight memory read data, valid the cycle after w_en
//   busy      run in progress
//   ready     one-cycle pulse, layer_out updated
//   layer_out packed signed results, node k at [k*DATA_WIDTH +: DATA_WIDTH]
// Modports: master = upstream stage plus weight memory, slave = fc_serial.
interface fc_serial_if #(
    parameter int INPUT_NODE   = 25,
    parameter int OUTPUT_NODE  = 10,
    parameter int DATA_WIDTH   = 19,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ADDR_WIDTH   = 9
);
    logic [DATA_WIDTH*INPUT_NODE-1:0]  layer_in;
    logic                              valid;
    logic [ADDR_WIDTH-1:0]             w_addr;
    logic                              w_en;
    logic [WEIGHT_WIDTH-1:0]           w_data;
    logic                              busy;
    logic                              ready;
    logic [DATA_WIDTH*OUTPUT_NODE-1:0] layer_out;

    modport master (
        output layer_in, valid, w_data,
        input  w_addr, w_en, busy, ready, layer_out
    );

    modport slave (
        input  layer_in, valid, w_data,
        output w_addr, w_en, busy, ready, layer_out
    );
endinterface

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply-accumulate with synchronous clear and bias-add path
// Ports:
//   clk, rst  clock, synchronous active-high reset (clears acc)
//   en        consume one word this cycle
//   bias_sel  word is a bias: acc is cleared instead of accumulated
//   x         signed data operand
//   w         signed weight or bias word
//   result    acc + (sign-extended w << FRAC_BITS), meaningful when bias_sel
module mac_unit #(
    parameter int DATA_WIDTH   = 19,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ACC_WIDTH    = 40,
    parameter int FRAC_BITS    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        bias_sel,
    input  logic signed [DATA_WIDTH-1:0]   x,
    input  logic signed [WEIGHT_WIDTH-1:0] w,
    output logic signed [ACC_WIDTH-1:0]    result
);
    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  bias_ext;

    assign prod     = PROD_WIDTH'(x) * PROD_WIDTH'(w);
    // Bias shares FRAC_BITS with the weights; align it to the Q(2*FRAC) product scale.
    assign bias_ext = ACC_WIDTH'(w) <<< FRAC_BITS;
    assign result   = acc + bias_ext;

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (en) begin
            if (bias_sel)
                acc <= '0;
            else
                acc <= acc + ACC_WIDTH'(prod);
        end
    end
endmodule

// File: rtl/fc_serial.sv
// rtl/fc_serial.sv - time-multiplexed fully connected layer with one MAC and streamed weights
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; aborts a run and zeroes layer_out
//   bus  fc_serial_if.slave: layer_in/valid in, w_addr/w_en/w_data weight memory,
//        busy/ready/layer_out out
// Build option: FC_RELU_EN clamps negative saturated outputs to 0.
module fc_serial
    import tcb_cnn_pkg::*;
#(
    parameter int INPUT_NODE   = 25,
    parameter int OUTPUT_NODE  = 10,
    parameter int DATA_WIDTH   = 19,
    parameter int WEIGHT_WIDTH = 16,
    parameter int FRAC_BITS    = 8,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic        clk,
    input  logic        rst,
    fc_serial_if.slave  bus
);
    localparam int K         = OUTPUT_NODE * (INPUT_NODE + 1);
    localparam int IW        = clog2(INPUT_NODE + 1);
    localparam int KW        = clog2(OUTPUT_NODE + 1);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, WEIGHT_WIDTH, INPUT_NODE);

    fc_state_t state, state_n;

    logic [IW-1:0] i_cnt, rd_i;
    logic [KW-1:0] k_cnt, rd_k;
    logic          rd_vld;
    logic          last_addr;
    logic          bias_word;

    // Extra zero entry at index INPUT_NODE is what the MAC sees on the bias word.
    logic signed [DATA_WIDTH-1:0] in_buf [0:INPUT_NODE];

    logic signed [ACC_WIDTH-1:0]  result;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [DATA_WIDTH-1:0] node_val;

    assign last_addr = (bus.w_addr == ADDR_WIDTH'(K - 1));
    assign bias_word = (rd_i == IW'(INPUT_NODE));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        bus.w_en = 1'b0;
        bus.busy = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.valid)
                    state_n = ST_RUN;
            end
            ST_RUN: begin
                bus.w_en = 1'b1;
                bus.busy = 1'b1;
                if (last_addr)
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Read data lags the address by one cycle; rd_* carry the matching indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.w_addr    <= '0;
            bus.ready     <= 1'b0;
            bus.layer_out <= '0;
            i_cnt         <= '0;
            k_cnt         <= '0;
            rd_i          <= '0;
            rd_k          <= '0;
            rd_vld        <= 1'b0;
            for (int j = 0; j <= INPUT_NODE; j++)
                in_buf[j] <= '0;
        end else begin
            bus.ready <= (state == ST_DONE);
            rd_vld    <= bus.w_en;
            rd_i      <= i_cnt;
            rd_k      <= k_cnt;

            if (state == ST_IDLE && bus.valid) begin
                for (int j = 0; j < INPUT_NODE; j++)
                    in_buf[j] <= signed'(bus.layer_in[j*DATA_WIDTH +: DATA_WIDTH]);
                in_buf[INPUT_NODE] <= '0;
                bus.w_addr <= '0;
                i_cnt      <= '0;
                k_cnt      <= '0;
            end else if (state == ST_RUN) begin
                if (!last_addr)
                    bus.w_addr <= bus.w_addr + 1'b1;
                if (i_cnt == IW'(INPUT_NODE)) begin
                    i_cnt <= '0;
                    k_cnt <= k_cnt + 1'b1;
                end else begin
                    i_cnt <= i_cnt + 1'b1;
                end
            end

            if (rd_vld && bias_word)
                bus.layer_out[rd_k*DATA_WIDTH +: DATA_WIDTH] <= node_val;
        end
    end

    mac_unit #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .ACC_WIDTH    (ACC_WIDTH),
        .FRAC_BITS    (FRAC_BITS)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (rd_vld),
        .bias_sel (bias_word),
        .x        (in_buf[rd_i]),
        .w        (signed'(bus.w_data)),
        .result   (result)
    );

    // Drop the product's extra FRAC_BITS; >>> floors toward minus infinity.
    assign shifted = result >>> FRAC_BITS;

`ifdef FC_RELU_EN
    logic signed [DATA_WIDTH-1:0] sat_val;
    assign sat_val  = DATA_WIDTH'(saturate(64'(shifted), DATA_WIDTH));
    assign node_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    assign node_val = DATA_WIDTH'(saturate(64'(shifted), DATA_WIDTH));
`endif

endmodule
